// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Lets the Ibex instruction and data ports share one single-port SRAM with
// 1-cycle read latency. Each cycle at most one requester is granted, and the
// grant is combinational (gnt = req & win). The owner of each grant (port and
// error flag) is registered so that exactly one cycle later the response goes
// back to that port. A winner whose address is outside the memory window is
// still granted. It gets no SRAM access and receives rvalid with err=1 and
// rdata=0.
//
// Default priority: instr wins. The exception is a data request that has lost
// MAX_WAIT cycles in a row; that request is then granted, so that continuous
// fetch cannot starve loads and stores.
//
// Build option: define SRAM_ARB_RR_EN to replace fixed priority with
// round-robin. On contention the port not granted last wins, and MAX_WAIT is
// ignored.
//
// Ports
//   clk_i, rst_i             clock, async active-high reset
//   instr_req/gnt/rvalid/err, instr_addr_i, instr_rdata_o   fetch port
//   data_req/gnt/rvalid/err, data_we/be/addr/wdata_i, data_rdata_o
//                            load/store port (rvalid also for stores)
//   mem_req/we/be/addr/wdata_o, mem_rvalid_i, mem_rdata_i   SRAM side
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
   parameter int unsigned MEM_SIZE  = 65536,
   parameter logic [31:0] MEM_START = 32'h0,
   parameter int unsigned MAX_WAIT  = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic        instr_err_o,
   input  logic [31:0] instr_addr_i,
   output logic [31:0] instr_rdata_o,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic        data_err_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam logic [31:0] WIN_MASK = ~(32'(MEM_SIZE) - 32'd1);

   logic       instr_in_win;
   logic       data_in_win;
   logic       instr_win;
   logic       data_win;
   logic [3:0] wait_cnt;
   logic       last_data;
   logic       rsp_instr;
   logic       rsp_data;
   logic       rsp_err;

   // The response is fixed one cycle after the grant by design, so the SRAM's
   // own valid strobe is never consulted.
   logic       unused_sigs;
`ifdef SRAM_ARB_RR_EN
   assign unused_sigs = mem_rvalid_i ^ (^wait_cnt);
`else
   assign unused_sigs = mem_rvalid_i ^ last_data;
`endif

   assign instr_in_win = (instr_addr_i & WIN_MASK) == MEM_START;
   assign data_in_win  = (data_addr_i  & WIN_MASK) == MEM_START;

   // Grants are gated by rst_i so that every output is quiet while reset is held.
   always_comb begin
`ifdef SRAM_ARB_RR_EN
      data_win = data_req_i && (!instr_req_i || !last_data) && !rst_i;
`else
      data_win = data_req_i && (!instr_req_i || (wait_cnt >= 4'(MAX_WAIT))) && !rst_i;
`endif
      instr_win = instr_req_i && !data_win && !rst_i;
   end

   assign instr_gnt_o = instr_win;
   assign data_gnt_o  = data_win;

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      if (instr_win && instr_in_win) begin
         mem_req_o  = 1'b1;
         mem_be_o   = 4'hF;
         mem_addr_o = instr_addr_i;
      end else if (data_win && data_in_win) begin
         mem_req_o   = 1'b1;
         mem_we_o    = data_we_i;
         mem_be_o    = data_be_i;
         mem_addr_o  = data_addr_i;
         mem_wdata_o = data_wdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_instr <= 1'b0;
         rsp_data  <= 1'b0;
         rsp_err   <= 1'b0;
         wait_cnt  <= 4'h0;
         last_data <= 1'b1;
      end else begin
         rsp_instr <= instr_win;
         rsp_data  <= data_win;
         rsp_err   <= (instr_win && !instr_in_win) || (data_win && !data_in_win);
         if (data_req_i && !data_win) begin
            if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'h1;
         end else begin
            wait_cnt <= 4'h0;
         end
         if (data_win)       last_data <= 1'b1;
         else if (instr_win) last_data <= 1'b0;
      end
   end

   assign instr_rvalid_o = rsp_instr;
   assign instr_err_o    = rsp_instr && rsp_err;
   assign instr_rdata_o  = (rsp_instr && !rsp_err) ? mem_rdata_i : 32'h0;
   assign data_rvalid_o  = rsp_data;
   assign data_err_o     = rsp_data && rsp_err;
   assign data_rdata_o   = (rsp_data && !rsp_err) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        instr_req_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic        instr_err_o;
   logic [31:0] instr_addr_i;
   logic [31:0] instr_rdata_o;
   logic        data_req_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic        data_err_o;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic [31:0] data_rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   int checks   = 0;
   int failures = 0;

   sram_port_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_err_o(instr_err_o),
      .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o),
      .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // SRAM model: byte-enabled write, 1-cycle read latency, read data held.
   logic [31:0] sram [0:255];
   always @(posedge clk_i) begin
      mem_rvalid_i <= mem_req_o && !mem_we_o;
      if (mem_req_o) begin
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_be_o[b]) sram[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
         end else begin
            mem_rdata_i <= sram[mem_addr_o[9:2]];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   task automatic idle();
      instr_req_i  = 1'b0;
      instr_addr_i = 32'h0;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_be_i    = 4'h0;
      data_addr_i  = 32'h0;
      data_wdata_i = 32'h0;
   endtask

   task automatic drive_data(input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata);
      data_req_i   = 1'b1;
      data_we_i    = we;
      data_be_i    = be;
      data_addr_i  = addr;
      data_wdata_i = wdata;
   endtask

   // Hand-computed grant sequences with both ports requesting continuously.
`ifdef SRAM_ARB_RR_EN
   logic exp_i [0:5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
   logic exp_i [0:5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif

   initial begin
      logic prev_i;
      logic prev_d;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      idle();
      rst_i       = 1'b1;
      instr_req_i = 1'b1;
      drive_data(1'b1, 4'hF, 32'h80, 32'h1);
      @(negedge clk_i);
      check("rst_instr_gnt",    {31'h0, instr_gnt_o},    32'h0);
      check("rst_data_gnt",     {31'h0, data_gnt_o},     32'h0);
      check("rst_instr_rvalid", {31'h0, instr_rvalid_o}, 32'h0);
      check("rst_data_rvalid",  {31'h0, data_rvalid_o},  32'h0);
      check("rst_mem_req",      {31'h0, mem_req_o},      32'h0);
      check("rst_mem_we",       {31'h0, mem_we_o},       32'h0);
      idle();
      rst_i = 1'b0;

      // preload SRAM through the data port
      @(negedge clk_i);
      drive_data(1'b1, 4'hF, 32'h80, 32'h0000_0013);
      #1 check("pre0_gnt", {31'h0, data_gnt_o}, 32'h1);
      @(negedge clk_i);
      drive_data(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
      #1 check("pre0_rvalid", {31'h0, data_rvalid_o}, 32'h1);
      @(negedge clk_i);
      idle();

      // instruction fetch
      @(negedge clk_i);
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h80;
      #1;
      check("t1_gnt",      {31'h0, instr_gnt_o}, 32'h1);
      check("t1_data_gnt", {31'h0, data_gnt_o},  32'h0);
      check("t1_mem_req",  {31'h0, mem_req_o},   32'h1);
      check("t1_mem_we",   {31'h0, mem_we_o},    32'h0);
      check("t1_mem_be",   {28'h0, mem_be_o},    32'hF);
      check("t1_mem_addr", mem_addr_o,           32'h80);
      @(negedge clk_i);
      idle();
      #1;
      check("t1_rvalid",      {31'h0, instr_rvalid_o}, 32'h1);
      check("t1_rdata",       instr_rdata_o,           32'h13);
      check("t1_err",         {31'h0, instr_err_o},    32'h0);
      check("t1_data_rvalid", {31'h0, data_rvalid_o},  32'h0);
      check("t1_data_rdata",  data_rdata_o,            32'h0);

      // partial store, then readback
      @(negedge clk_i);
      drive_data(1'b1, 4'b0011, 32'h100, 32'hA5A5_1234);
      #1;
      check("t2_gnt",       {31'h0, data_gnt_o}, 32'h1);
      check("t2_mem_we",    {31'h0, mem_we_o},   32'h1);
      check("t2_mem_be",    {28'h0, mem_be_o},   32'h3);
      check("t2_mem_wdata", mem_wdata_o,         32'hA5A5_1234);
      @(negedge clk_i);
      drive_data(1'b0, 4'hF, 32'h100, 32'h0);
      #1;
      check("t2_rvalid",   {31'h0, data_rvalid_o}, 32'h1);
      check("t2_err",      {31'h0, data_err_o},    32'h0);
      check("t2_rd_gnt",   {31'h0, data_gnt_o},    32'h1);
      check("t2_rd_mem_we", {31'h0, mem_we_o},     32'h0);
      @(negedge clk_i);
      idle();
      #1;
      check("t2_rd_rvalid", {31'h0, data_rvalid_o}, 32'h1);
      check("t2_rd_rdata",  data_rdata_o,           32'hDEAD_1234);

      // out-of-window load
      @(negedge clk_i);
      drive_data(1'b0, 4'hF, 32'h0001_0000, 32'h0);
      #1;
      check("t5_gnt",     {31'h0, data_gnt_o}, 32'h1);
      check("t5_mem_req", {31'h0, mem_req_o},  32'h0);
      @(negedge clk_i);
      idle();
      #1;
      check("t5_rvalid", {31'h0, data_rvalid_o}, 32'h1);
      check("t5_err",    {31'h0, data_err_o},    32'h1);
      check("t5_rdata",  data_rdata_o,           32'h0);

      // continuous contention
      @(negedge clk_i);
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h80;
      drive_data(1'b0, 4'hF, 32'h100, 32'h0);
      prev_i = 1'b0;
      prev_d = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("t3_instr_gnt%0d", k),  {31'h0, instr_gnt_o},    {31'h0, exp_i[k]});
         check($sformatf("t3_data_gnt%0d", k),   {31'h0, data_gnt_o},     {31'h0, !exp_i[k]});
         check($sformatf("t3_instr_rv%0d", k),   {31'h0, instr_rvalid_o}, {31'h0, prev_i});
         check($sformatf("t3_data_rv%0d", k),    {31'h0, data_rvalid_o},  {31'h0, prev_d});
         check($sformatf("t3_instr_rd%0d", k),   instr_rdata_o, prev_i ? 32'h13 : 32'h0);
         check($sformatf("t3_data_rd%0d", k),    data_rdata_o,  prev_d ? 32'hDEAD_1234 : 32'h0);
         prev_i = exp_i[k];
         prev_d = !exp_i[k];
         @(negedge clk_i);
      end
      idle();
      #1;
      check("t3_last_instr_rv", {31'h0, instr_rvalid_o}, {31'h0, prev_i});
      check("t3_last_data_rv",  {31'h0, data_rvalid_o},  {31'h0, prev_d});

      // reset right after an instruction grant drops the pending response
      @(negedge clk_i);
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h80;
      #1 check("t6_gnt", {31'h0, instr_gnt_o}, 32'h1);
      #2 rst_i = 1'b1;
      @(negedge clk_i);
      #1;
      check("t6_rst_rvalid",  {31'h0, instr_rvalid_o}, 32'h0);
      check("t6_rst_gnt",     {31'h0, instr_gnt_o},    32'h0);
      check("t6_rst_mem_req", {31'h0, mem_req_o},      32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("t6_post_rvalid", {31'h0, instr_rvalid_o}, 32'h0);
      check("t6_post_gnt",    {31'h0, instr_gnt_o},    32'h1);
      @(negedge clk_i);
      idle();
      #1;
      check("t6_post_rv2",   {31'h0, instr_rvalid_o}, 32'h1);
      check("t6_post_rdata", instr_rdata_o,           32'h13);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
